jtag_dmi_master: RTL and testbench

- Synthesizable JTAG debug-transport master that turns single DMI requests (op, address, data) into complete TAP pin sequences on TCK/TMS/TDI, and returns the DMI result sampled from TDO.
- Parametrised in DMI address width, IR width/code, TCK divider, run-idle padding and busy-retry count.
- Sits on the SoC side of `jtag_top` (or in a bench harness), replacing hand-toggled TAP sequences with a request/response handshake, automatic result fetch and busy retry.

---
 rtl/jtag_dmi_pkg.sv | 30 +++
 rtl/jtag_tck_gen.sv | 48 ++++
 rtl/jtag_dmi_master.sv | 191 +++++++++++++++++++
 tb/tb_jtag_dmi_master.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dmi_pkg.sv
// rtl/jtag_dmi_pkg.sv - shared types and constants for the JTAG DMI master
package jtag_dmi_pkg;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2
    } dmi_op_e;

    localparam logic [1:0] ST_SUCCESS = 2'd0;
    localparam logic [1:0] ST_FAILED  = 2'd2;
    localparam logic [1:0] ST_BUSY    = 2'd3;

    typedef enum logic [2:0] {
        S_TAP_RST,
        S_IR_LOAD,
        S_IDLE,
        S_SCAN_OP,
        S_SCAN_NOP,
        S_RESP
    } state_e;

    localparam logic [4:0] DMI_IR_DEFAULT = 5'h11;

    // DMI data register: {addr, 32-bit data, 2-bit op/status}
    function automatic int dmi_drw(input int abits);
        return abits + 34;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - TCK divider: low phase then high phase of CLK_DIV clk each
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic tck_rise_o,
    output logic tck_fall_o,
    output logic tck_o
);

    localparam int CW = $clog2(2 * CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;

    // tck_fall also closes a tick; the next tick's TMS/TDI launch on that edge
    assign tck_rise_o = run_i && (cnt_q == CW'(CLK_DIV - 1));
    assign tck_fall_o = run_i && (cnt_q == CW'(2 * CLK_DIV - 1));
    assign tck_o      = tck_q;

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!run_i) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (tck_fall_o) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (tck_rise_o) tck_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/jtag_dmi_master.sv
// rtl/jtag_dmi_master.sv - turns DMI requests into TAP scans and returns the DMI result
module jtag_dmi_master
    import jtag_dmi_pkg::*;
#(
    parameter int                  ABITS      = 6,
    parameter int                  IR_WIDTH   = 5,
    parameter logic [IR_WIDTH-1:0] DMI_IR     = IR_WIDTH'(DMI_IR_DEFAULT),
    parameter int                  CLK_DIV    = 2,
    parameter int                  IDLE_TICKS = 1,
    parameter int                  RETRY_MAX  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [ABITS-1:0] req_addr_i,
    input  logic [31:0]      req_data_i,
    output logic             rsp_valid_o,
    output logic [1:0]       rsp_status_o,
    output logic [31:0]      rsp_data_o,
    output logic             tck_o,
    output logic             tms_o,
    output logic             tdi_o,
    input  logic             tdo_i
);

    localparam int DRW        = dmi_drw(ABITS);
    localparam int SCAN_TICKS = DRW + 5 + IDLE_TICKS;
    localparam int IR_TICKS   = IR_WIDTH + 7;
    localparam int TW         = $clog2((SCAN_TICKS > IR_TICKS ? SCAN_TICKS : IR_TICKS) + 1);
    localparam int RW         = $clog2(RETRY_MAX + 2);

    state_e              state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [DRW-1:0]      shift_q, shift_d;
    logic [ABITS-1:0]    addr_q, addr_d;
    logic                tms_q, tms_d, tdi_q, tdi_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [1:0]          rsp_status_q, rsp_status_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                tck_rise, tck_fall, tck_run;
    logic                tick_last, in_scan, dr_shift, accept;
    logic [1:0]          op_sent;
    logic [DRW-1:0]      nop_word;
    logic [IR_WIDTH-1:0] ir_bits;

    assign tck_run  = (state_q != S_IDLE) && (state_q != S_RESP);
    assign in_scan  = (state_q == S_SCAN_OP) || (state_q == S_SCAN_NOP);
    assign dr_shift = in_scan && (tick_q >= TW'(3)) && (tick_q < TW'(3 + DRW));
    assign accept   = (state_q == S_IDLE) && req_valid_i;
    assign op_sent  = (req_op_i == DMI_READ || req_op_i == DMI_WRITE) ? req_op_i : DMI_NOP;
    assign nop_word = {addr_q, 32'h0, DMI_NOP};

    assign req_ready_o  = (state_q == S_IDLE);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_status_o = rsp_status_q;
    assign rsp_data_o   = rsp_data_q;
    assign tms_o        = tms_q;
    assign tdi_o        = tdi_q;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk        (clk),
        .rst        (rst),
        .run_i      (tck_run),
        .tck_rise_o (tck_rise),
        .tck_fall_o (tck_fall),
        .tck_o      (tck_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_TAP_RST;
            tick_q       <= '0;
            retry_q      <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            tms_q        <= 1'b1;
            tdi_q        <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_SUCCESS;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            retry_q      <= retry_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            tms_q        <= tms_d;
            tdi_q        <= tdi_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    always_comb begin
        tick_last = 1'b0;
        case (state_q)
            S_TAP_RST:              tick_last = (tick_q == TW'(7));
            S_IR_LOAD:              tick_last = (tick_q == TW'(IR_TICKS - 1));
            S_SCAN_OP, S_SCAN_NOP:  tick_last = (tick_q == TW'(SCAN_TICKS - 1));
            default:                tick_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        retry_d = retry_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        // TDO is captured on the same clk edge that raises TCK
        if (tck_rise && dr_shift) shift_d = {tdo_i, shift_q[DRW-1:1]};
        if (tck_fall) tick_d = tick_last ? '0 : tick_q + TW'(1);
        case (state_q)
            S_TAP_RST:  if (tck_fall && tick_last) state_d = S_IR_LOAD;
            S_IR_LOAD:  if (tck_fall && tick_last) state_d = S_IDLE;
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_SCAN_OP;
                    tick_d  = '0;
                    retry_d = '0;
                    addr_d  = req_addr_i;
                    shift_d = {req_addr_i, req_data_i, op_sent};
                end
            end
            S_SCAN_OP: begin
                if (tck_fall && tick_last) begin
                    state_d = S_SCAN_NOP;
                    shift_d = nop_word;
                end
            end
            S_SCAN_NOP: begin
                if (tck_fall && tick_last) begin
                    if (shift_q[1:0] == ST_BUSY && retry_q < RW'(RETRY_MAX)) begin
                        retry_d = retry_q + RW'(1);
                        shift_d = nop_word;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_TAP_RST;
        endcase
    end

    always_comb begin
        tms_d        = tms_q;
        tdi_d        = tdi_q;
        ir_bits      = DMI_IR >> (tick_d - TW'(5));
        rsp_valid_d  = (state_q == S_RESP);
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
        if (tck_fall || accept) begin
            tms_d = 1'b0;
            tdi_d = 1'b1;
            case (state_d)
                S_TAP_RST: tms_d = 1'b1;
                S_IR_LOAD: begin
                    if (tick_d < TW'(5)) begin
                        tms_d = (tick_d == TW'(1)) || (tick_d == TW'(2));
                    end else if (tick_d < TW'(5 + IR_WIDTH)) begin
                        tdi_d = ir_bits[0];
                        tms_d = (tick_d == TW'(4 + IR_WIDTH));
                    end else begin
                        tms_d = (tick_d == TW'(5 + IR_WIDTH));
                    end
                end
                S_SCAN_OP, S_SCAN_NOP: begin
                    if (tick_d < TW'(3)) begin
                        tms_d = (tick_d == TW'(0));
                    end else if (tick_d < TW'(3 + DRW)) begin
                        tdi_d = shift_d[0];
                        tms_d = (tick_d == TW'(2 + DRW));
                    end else begin
                        tms_d = (tick_d == TW'(3 + DRW));
                    end
                end
                default: tms_d = 1'b0;
            endcase
        end
        if (state_q == S_RESP) begin
            rsp_status_d = (shift_q[1:0] == 2'd1) ? ST_FAILED : shift_q[1:0];
            rsp_data_d   = shift_q[33:2];
        end
    end

endmodule

// File: tb/tb_jtag_dmi_master.sv
// tb/tb_jtag_dmi_master.sv - directed bench for jtag_dmi_master with a behavioural TAP
module tb_jtag_dmi_master;

    localparam int S = 184;
    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
    localparam int UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic [1:0]  req_op_i = '0;
    logic [5:0]  req_addr_i = '0;
    logic [31:0] req_data_i = '0;
    logic        tdo_i = 1'b0;
    logic        req_ready_o, rsp_valid_o, tck_o, tms_o, tdi_o;
    logic [1:0]  rsp_status_o;
    logic [31:0] rsp_data_o;

    int n_checks = 0;
    int n_fail = 0;

    jtag_dmi_master dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_status_o (rsp_status_o),
        .rsp_data_o   (rsp_data_o),
        .tck_o        (tck_o),
        .tms_o        (tms_o),
        .tdi_o        (tdi_o),
        .tdo_i        (tdo_i)
    );

    always #5 clk = ~clk;

    // Behavioural TAP: scan i captures cap[i] and logs the word shifted in
    int          tap_st = TLR;
    logic [39:0] dr = '0;
    logic [4:0]  ir_sh = '0;
    logic [4:0]  ir_reg = '0;
    int          nscan = 0, ir_upd = 0, ones = 0, last_ones = 0, base = 0, rsp_cnt = 0;
    logic [39:0] cap [16];
    logic [39:0] scan_log [16];
    logic [3:0]  sidx;

    assign sidx = 4'(nscan - base);

    function automatic int tap_next(input int s, input logic tms);
        case (s)
            TLR:  return tms ? TLR  : RTI;
            RTI:  return tms ? SDR  : RTI;
            SDR:  return tms ? SIR  : CDR;
            CDR:  return tms ? E1DR : SHDR;
            SHDR: return tms ? E1DR : SHDR;
            E1DR: return tms ? UDR  : PDR;
            PDR:  return tms ? E2DR : PDR;
            E2DR: return tms ? UDR  : SHDR;
            UDR:  return tms ? SDR  : RTI;
            SIR:  return tms ? TLR  : CIR;
            CIR:  return tms ? E1IR : SHIR;
            SHIR: return tms ? E1IR : SHIR;
            E1IR: return tms ? UIR  : PIR;
            PIR:  return tms ? E2IR : PIR;
            E2IR: return tms ? UIR  : SHIR;
            default: return tms ? SDR : RTI;
        endcase
    endfunction

    always @(posedge tck_o) begin
        case (tap_st)
            CDR:  dr <= cap[sidx];
            SHDR: dr <= {tdi_o, dr[39:1]};
            UDR:  begin scan_log[sidx] <= dr; nscan <= nscan + 1; end
            CIR:  ir_sh <= 5'b00001;
            SHIR: ir_sh <= {tdi_o, ir_sh[4:1]};
            UIR:  begin ir_reg <= ir_sh; ir_upd <= ir_upd + 1; end
            default: ;
        endcase
        if (tms_o) ones <= ones + 1;
        else begin
            if (tap_st == TLR) last_ones <= ones;
            ones <= 0;
        end
        tap_st <= tap_next(tap_st, tms_o);
    end

    always @(negedge tck_o)
        tdo_i <= (tap_st == SHDR) ? dr[0] : (tap_st == SHIR) ? ir_sh[0] : 1'b0;

    always @(posedge clk) if (rsp_valid_o) rsp_cnt <= rsp_cnt + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic release_and_wait(output int n);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (req_ready_o) break;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (rsp_valid_o) break;
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] data,
                          output int lat);
        @(negedge clk);
        check_eq("ready_before_req", 64'(req_ready_o), 1);
        base = nscan;
        req_op_i = op;
        req_addr_i = addr;
        req_data_i = data;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        wait_rsp(lat);
    endtask

    initial begin
        int n;
        int cnt0, irupd0;
        for (int i = 0; i < 16; i++) cap[i] = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_tck", 64'(tck_o), 0);
        check_eq("rst_tms", 64'(tms_o), 1);
        check_eq("rst_tdi", 64'(tdi_o), 1);
        check_eq("rst_ready", 64'(req_ready_o), 0);
        check_eq("rst_rsp_valid", 64'(rsp_valid_o), 0);
        check_eq("rst_rsp_status", 64'(rsp_status_o), 0);
        check_eq("rst_rsp_data", 64'(rsp_data_o), 0);

        release_and_wait(n);
        check_eq("init_latency", 64'(n), 80);
        check_eq("init_tms_ones", 64'(last_ones), 8);
        check_eq("init_ir", 64'(ir_reg), 64'h11);
        check_eq("init_tap_idle", 64'(tap_st), RTI);
        check_eq("idle_tck_low", 64'(tck_o), 0);

        cap[1] = {6'h10, 32'h0, 2'b00};
        do_req(2'd2, 6'h10, 32'h1, n);
        check_eq("wr_latency", 64'(n), 2 * S + 1);
        check_eq("wr_op_word", 64'(scan_log[0]), 64'h40_0000_0006);
        check_eq("wr_nop_word", 64'(scan_log[1]), 64'h40_0000_0000);
        check_eq("wr_scans", 64'(nscan - base), 2);
        check_eq("wr_status", 64'(rsp_status_o), 0);

        cap[1] = {6'h11, 32'h0003_0382, 2'b00};
        do_req(2'd1, 6'h11, 32'h0, n);
        check_eq("rd_latency", 64'(n), 2 * S + 1);
        check_eq("rd_op_word", 64'(scan_log[0]), 64'h44_0000_0001);
        check_eq("rd_data", 64'(rsp_data_o), 64'h0003_0382);
        check_eq("rd_status", 64'(rsp_status_o), 0);
        repeat (10) @(negedge clk);
        check_eq("rd_hold_data", 64'(rsp_data_o), 64'h0003_0382);
        check_eq("rd_pulse_low", 64'(rsp_valid_o), 0);

        cap[1] = {6'h03, 32'h0, 2'b11};
        cap[2] = {6'h03, 32'h0, 2'b11};
        cap[3] = {6'h03, 32'hdead_beef, 2'b00};
        do_req(2'd3, 6'h03, 32'h0, n);
        check_eq("nop_op_word", 64'(scan_log[0]), 64'h0C_0000_0000);
        check_eq("busy2_latency", 64'(n), 4 * S + 1);
        check_eq("busy2_scans", 64'(nscan - base), 4);
        check_eq("busy2_data", 64'(rsp_data_o), 64'hdead_beef);
        check_eq("busy2_status", 64'(rsp_status_o), 0);

        for (int i = 1; i < 8; i++) cap[i] = {6'h04, 32'h0, 2'b11};
        do_req(2'd1, 6'h04, 32'h0, n);
        check_eq("busyinf_latency", 64'(n), 6 * S + 1);
        check_eq("busyinf_scans", 64'(nscan - base), 6);
        check_eq("busyinf_status", 64'(rsp_status_o), 3);

        cap[1] = {6'h05, 32'h1234_5678, 2'b01};
        do_req(2'd1, 6'h05, 32'h0, n);
        check_eq("st1_status", 64'(rsp_status_o), 2);
        check_eq("st1_data", 64'(rsp_data_o), 64'h1234_5678);

        @(negedge clk);
        base = nscan;
        cap[1] = {6'h07, 32'haaaa_5555, 2'b00};
        cap[3] = {6'h07, 32'h5555_aaaa, 2'b00};
        req_op_i = 2'd1;
        req_addr_i = 6'h07;
        req_valid_i = 1'b1;
        @(posedge clk);
        wait_rsp(n);
        check_eq("b2b_latency1", 64'(n), 2 * S + 1);
        check_eq("b2b_ready_in_rsp", 64'(req_ready_o), 1);
        check_eq("b2b_data1", 64'(rsp_data_o), 64'haaaa_5555);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        check_eq("b2b_accepted", 64'(req_ready_o), 0);
        wait_rsp(n);
        check_eq("b2b_latency2", 64'(n), 2 * S + 1);
        check_eq("b2b_data2", 64'(rsp_data_o), 64'h5555_aaaa);

        @(negedge clk);
        base = nscan;
        irupd0 = ir_upd;
        req_op_i = 2'd2;
        req_addr_i = 6'h09;
        req_data_i = 32'hcafe_f00d;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (20) @(posedge tck_o);
        @(negedge clk);
        cnt0 = rsp_cnt;
        rst = 1'b0;
        #1;
        check_eq("midrst_tck", 64'(tck_o), 0);
        check_eq("midrst_tms", 64'(tms_o), 1);
        check_eq("midrst_tdi", 64'(tdi_o), 1);
        check_eq("midrst_ready", 64'(req_ready_o), 0);
        check_eq("midrst_rsp_valid", 64'(rsp_valid_o), 0);
        repeat (5) @(negedge clk);
        release_and_wait(n);
        check_eq("reinit_latency", 64'(n), 80);
        check_eq("reinit_tms_ones", 64'(last_ones), 8);
        check_eq("reinit_ir_loads", 64'(ir_upd - irupd0), 1);
        check_eq("reinit_ir", 64'(ir_reg), 64'h11);
        check_eq("reinit_tap_idle", 64'(tap_st), RTI);
        repeat (20) @(negedge clk);
        check_eq("midrst_no_rsp", 64'(rsp_cnt), 64'(cnt0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
